// File: rtl/cp0_pkg.sv
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared constants for the coprocessor-0 interrupt controller:
//                CP0 register numbers, ExcCode values and SR/Cause bit fields.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  // CP0 register numbers (mfc0/mtc0 sel field)
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // Exception codes recorded in Cause.ExcCode
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Status register field positions
  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;

  // Cause register field positions
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_TI_BIT  = 30;

  // EPC holds a word address; byte address bits [1:0] read as zero
  localparam int EPC_LSB = 2;

endpackage

`default_nettype wire

// File: rtl/cp0_prio_enc.sv
// ============================================================================
//  Module      : cp0_prio_enc
//  Description : Priority encoder over the masked interrupt vector. The
//                highest-numbered set line wins; index 0 when nothing is set.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_prio_enc #(
  parameter int NUM_HWINT = 6
) (
  input  logic [NUM_HWINT-1:0] i_vec,
  output logic [2:0]           o_id,
  output logic                 o_any
);

  // Scan upward so the last (highest) set bit overrides lower ones
  always_comb begin
    o_id  = 3'd0;
    o_any = 1'b0;
    for (int i = 0; i < NUM_HWINT; i++) begin
      if (i_vec[i]) begin
        o_id  = 3'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cp0_intc.sv
// ============================================================================
//  Module      : cp0_intc
//  Description : Coprocessor-0 for the pipelined MIPS core. Holds SR, Cause,
//                EPC and PrID, samples hardware interrupt lines into Cause.IP,
//                masks them with SR and reports the winning line.
//                Optional Count/Compare timer enabled by macro CP0_TIMER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_intc
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter int          PC_W      = 30,
  parameter logic [31:0] PRID_VAL  = 32'hBBAACCFF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_HWINT-1:0] i_hw_int,
  input  logic                 i_exl_set,
  input  logic                 i_exl_clr,
  input  logic [4:0]           i_exc_code,
  input  logic [PC_W-1:0]      i_epc_pc,
  input  logic                 i_wen,
  input  logic [4:0]           i_sel,
  input  logic [31:0]          i_din,
  output logic [31:0]          o_dout,
  output logic [PC_W-1:0]      o_epc,
  output logic                 o_int_req,
  output logic [2:0]           o_int_id
);

  // Architectural state
  logic [NUM_HWINT-1:0] r_im;
  logic                 r_ie;
  logic                 r_exl;
  logic [NUM_HWINT-1:0] r_ip;
  logic [4:0]           r_exc_code;
  logic [PC_W-1:0]      r_epc;

  logic                 w_wr_sr;
  logic                 w_wr_epc;
  logic                 w_ti;
  logic [NUM_HWINT-1:0] w_ti_vec;
  logic [NUM_HWINT-1:0] w_line_vec;
  logic [NUM_HWINT-1:0] w_masked;
  logic                 w_pend_any;
  logic [31:0]          w_sr;
  logic [31:0]          w_cause;

  assign w_wr_sr  = i_wen && (i_sel == CP0_SR);
  assign w_wr_epc = i_wen && (i_sel == CP0_EPC);

  // SR: IM/IE follow mtc0; EXL priority is entry > eret > mtc0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_im  <= '0;
      r_ie  <= 1'b0;
      r_exl <= 1'b0;
    end else begin
      if (w_wr_sr) begin
        r_im <= i_din[SR_IM_LSB +: NUM_HWINT];
        r_ie <= i_din[SR_IE_BIT];
      end
      if (i_exl_set) begin
        r_exl <= 1'b1;
      end else if (i_exl_clr) begin
        r_exl <= 1'b0;
      end else if (w_wr_sr) begin
        r_exl <= i_din[SR_EXL_BIT];
      end
    end
  end

  // EPC and ExcCode capture on exception entry; entry beats an mtc0 to EPC
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_epc      <= '0;
      r_exc_code <= 5'd0;
    end else begin
      if (i_exl_set) begin
        r_epc      <= i_epc_pc;
        r_exc_code <= i_exc_code;
      end else if (w_wr_epc) begin
        r_epc <= i_din[EPC_LSB +: PC_W];
      end
    end
  end

  // Sample interrupt lines into IP; frozen while a handler runs (EXL=1)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ip <= '0;
    end else if (!r_exl) begin
      r_ip <= w_line_vec;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_wr_count   = i_wen && (i_sel == CP0_COUNT);
  assign w_wr_compare = i_wen && (i_sel == CP0_COMPARE);

  // Free-running Count; a software write takes precedence over the increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 32'd0;
    end else if (w_wr_count) begin
      r_count <= i_din;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  // Compare register plus sticky timer flag; writing Compare acknowledges it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_compare) begin
        r_compare <= i_din;
        r_ti      <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_ti = r_ti;
`else
  assign w_ti = 1'b0;
`endif

  // Timer flag shares the top hardware line
  always_comb begin
    w_ti_vec                = '0;
    w_ti_vec[NUM_HWINT-1]   = w_ti;
  end

  assign w_line_vec = i_hw_int | w_ti_vec;
  assign w_masked   = r_ip & r_im;

  cp0_prio_enc #(
    .NUM_HWINT (NUM_HWINT)
  ) u_prio_enc (
    .i_vec (w_masked),
    .o_id  (o_int_id),
    .o_any (w_pend_any)
  );

  assign o_int_req = w_pend_any & r_ie & ~r_exl;
  assign o_epc     = r_epc;

  // Assemble SR and Cause images from their fields
  always_comb begin
    w_sr                              = 32'd0;
    w_sr[SR_IM_LSB +: NUM_HWINT]      = r_im;
    w_sr[SR_EXL_BIT]                  = r_exl;
    w_sr[SR_IE_BIT]                   = r_ie;
    w_cause                           = 32'd0;
    w_cause[CAUSE_TI_BIT]             = w_ti;
    w_cause[CAUSE_IP_LSB +: NUM_HWINT] = r_ip;
    w_cause[CAUSE_EXC_LSB +: 5]       = r_exc_code;
  end

  // mfc0 read mux; unmapped register numbers read zero
  always_comb begin
    o_dout = 32'd0;
    case (i_sel)
      CP0_SR:      o_dout = w_sr;
      CP0_CAUSE:   o_dout = w_cause;
      CP0_EPC:     o_dout = 32'({r_epc, 2'b00});
      CP0_PRID:    o_dout = PRID_VAL;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   o_dout = r_count;
      CP0_COMPARE: o_dout = r_compare;
`endif
      default:     o_dout = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
Parametrised coprocessor-0 for the pipelined MIPS core. It holds SR, Cause, EPC and PrID, and adds an optional Count/Compare timer.
- Hardware interrupt lines are sampled synchronously into Cause.IP and masked by SR.IM/IE/EXL.
- A priority encoder produces an interrupt request plus the winning line index.
- It sits beside the EX stage (mfc0/mtc0 port) and is controlled by the hazard/exception unit (EXL set/clear, EPC capture from ID).

Parameters:
- NUM_HWINT, 6, number of hardware interrupt lines (1..6); line i maps to IM/IP bit 10+i.
- PC_W, 30, width of word-addressed PC captured into EPC.
- PRID_VAL, 32'hBBAACCFF, constant returned by PrID.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- hw_int  in  NUM_HWINT  level interrupt lines, synchronous to clk
- exl_set  in  1  exception/interrupt entry this cycle
- exl_clr  in  1  eret this cycle
- exc_code  in  5  ExcCode to record on entry (0 = interrupt)
- epc_pc  in  PC_W  word PC to save on entry
- wen  in  1  mtc0 write enable
- sel  in  5  CP0 register number
- din  in  32  mtc0 data
- dout  out  32  mfc0 data (combinational from sel)
- epc  out  PC_W  current EPC (to PC mux for eret)
- int_req  out  1  enabled interrupt pending
- int_id  out  3  index of highest-numbered pending enabled line

Behaviour:
- Register map:
  - SR(12) = {16'b0, IM[15:10], 8'b0, EXL, IE}
  - Cause(13) = {1'b0, TI, 14'b0, IP[15:10], 3'b0, ExcCode, 2'b0}
  - EPC(14) = {epc, 2'b00}
  - PrID(15) = PRID_VAL
  - all other sel read 0
  - IM/IP bits at or above NUM_HWINT read 0 and are not writable.
- Reset (async, rst=0, any cycle incl. mid-entry): IM=0, IE=0, EXL=0, IP=0, ExcCode=0, epc=0, TI=0, Count=0, Compare=0. Hence int_req=0, int_id=0.
- IP sampling: each posedge, if EXL=0 then IP <= line vector, else IP holds (frozen during handler). Line vector = hw_int, with TI ORed into bit NUM_HWINT-1 when the timer feature is on.
- int_req = |(IP & IM) & IE & ~EXL, combinational from registers. Latency: hw_int at edge N gives int_req valid after edge N.
- int_id: highest set bit of IP&IM; 0 when none.
- mtc0: on posedge with wen:
  - sel12 loads IM, EXL, IE from din[15:10], din[1], din[0].
  - sel14 loads epc from din[31:2].
  - sel13 and sel15 are read-only; writes are ignored.
- Entry: exl_set at posedge sets EXL=1, epc<=epc_pc, ExcCode<=exc_code.
- eret: exl_clr clears EXL.
- Simultaneous events:
  - exl_set beats exl_clr.
  - exl_set beats mtc0 on EXL and epc; a same-cycle sel12 write still updates IM and IE.
  - exl_clr with a sel12 write: EXL=0 and IM/IE from din.
- No wrap/width hazards besides the Count wrap below.

Optional Feature:
Macro CP0_TIMER_EN.
- Defined:
  - Count(9) increments every cycle, wrapping 32'hFFFFFFFF to 0; a mtc0 to Count loads din and beats the increment.
  - Compare(11) is read/write.
  - TI sets the cycle after Count==Compare (Compare != 0) and is cleared by any mtc0 to Compare (clear beats set).
  - TI is visible in Cause[30] and drives line NUM_HWINT-1.
- Undefined: Count/Compare/TI are absent, sel9/11 read 0, writes are ignored, Cause[30]=0.

Decomposition:
- Shared package cp0_pkg holds:
  - register-number constants: CP0_COUNT=9, CP0_COMPARE=11, CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15
  - ExcCode constants: EXC_INT=0, EXC_ADEL=4, EXC_SYS=8, EXC_RI=10, EXC_OV=12
  - SR/Cause bit-position constants
- One sub-module cp0_prio_enc (parametrised NUM_HWINT): masked vector in, int_id plus any-valid out.

Test Plan:
- Reset mid-operation:
  - Stimulus: EXL=1, IM=6'h3F, then rst=0 asynchronously.
  - Response: within the same cycle, int_req=0 and dout(sel12)=0; dout(sel15)=32'hBBAACCFF.
- Enabled interrupt:
  - Stimulus: mtc0 sel12 din=32'h00000401; hw_int=6'b000001.
  - Response: next cycle int_req=1, int_id=0, dout(sel13)=32'h00000400.
- Entry and eret:
  - Stimulus: exl_set with epc_pc=30'h400, exc_code=0; then hw_int=6'b000010.
  - Response: int_req=0, Cause IP stays 6'b000001, dout(sel14)=32'h00001000.
  - Stimulus: exl_clr.
  - Response: EXL=0; the cycle after, IP=6'b000010.
- Collision:
  - Stimulus: same edge wen sel14 din=32'h00002000 and exl_set epc_pc=30'h10.
  - Response: dout(sel14)=32'h00000040, ExcCode from exc_code.
- Priority:
  - Stimulus: IM=6'h3F, IE=1, hw_int=6'b101000.
  - Response: int_id=5.
  - Stimulus: IM=6'b001111.
  - Response: int_id=3.
- Timer (CP0_TIMER_EN):
  - Stimulus: Compare=5, Count=0.
  - Response: TI=1 the cycle after Count=5; Cause[30]=1; IP[15]=1.
  - Stimulus: mtc0 Compare=10.
  - Response: TI=0.
  - Stimulus: Count=32'hFFFFFFFF.
  - Response: wraps to 0.
